play_controller: RTL

PLAY_CONTROLLER -- requirements
Module: play_controller

---
 rtl/play_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/play_controller.sv
// play_controller: single-cell falling-block game controller.
//   A one-cell block spawns at (SPAWN_X, 0). It falls on tick or btn_down and
//   slides on btn_left / btn_right. When it can no longer fall it is merged
//   into the board. Full rows are then found by a bottom-up scan and removed
//   one per cycle, and each removed row adds one to the score.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   tick               gravity pulse (one clk wide)
//   btn_left/right     lateral move requests (one-cycle pulses)
//   btn_down           soft-drop request (one-cycle pulse)
//   board              settled cells, bit y*BOARD_W+x, 1 = occupied
//   block_xpos/ypos    falling block position, row 0 is the top
//   block_type         always BLOCK_SINGLE
//   block_valid        block is live (FALL only)
//   busy               controller not accepting input (not FALL)
//   game_over          spawn cell was occupied; held until reset
//   score              cleared rows, saturating
`ifndef BLOCK_SINGLE
`define BLOCK_SINGLE 8'd1
`endif

module play_controller #(
  parameter int BOARD_W = 16,
  parameter int BOARD_H = 16,
  parameter int SPAWN_X = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_down,
  output logic [BOARD_W*BOARD_H-1:0] board,
  output logic [7:0]                 block_xpos,
  output logic [7:0]                 block_ypos,
  output logic [7:0]                 block_type,
  output logic                       block_valid,
  output logic                       busy,
  output logic                       game_over,
  output logic [15:0]                score
);

  localparam int CB = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
  localparam int RB = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;

  typedef enum logic [2:0] {SPAWN, FALL, LOCK, SCAN, SHIFT, GAMEOVER} state_t;

  typedef struct packed {
    logic down;
    logic left;
    logic right;
  } move_req_t;

  state_t    state_q, state_d;
  // Packed row-major grid: row y occupies bits y*BOARD_W +: BOARD_W, which is
  // exactly the flat board layout, so it is output without reshuffling.
  logic [BOARD_H-1:0][BOARD_W-1:0] grid_q, grid_d;
  logic [7:0]  xpos_q, xpos_d, ypos_q, ypos_d;
  logic [RB-1:0] row_q, row_d;
  logic [15:0] score_q, score_d;
  logic [CB-1:0] cx;
  logic [RB-1:0] cy;
  move_req_t   req;

  assign cx  = xpos_q[CB-1:0];
  assign cy  = ypos_q[RB-1:0];
  // tick and btn_down in the same cycle collapse into a single down step.
  assign req = '{down: tick | btn_down, left: btn_left, right: btn_right};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SPAWN;
      grid_q  <= '0;
      xpos_q  <= 8'(SPAWN_X);
      ypos_q  <= '0;
      row_q   <= RB'(BOARD_H - 1);
      score_q <= '0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      row_q   <= row_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    row_d   = row_q;
    score_d = score_q;
    case (state_q)
      SPAWN: begin
        if (grid_q[0][SPAWN_X]) begin
          state_d = GAMEOVER;
        end else begin
          xpos_d  = 8'(SPAWN_X);
          ypos_d  = '0;
          state_d = FALL;
        end
      end
      FALL: begin
        // The cell-below lookup wraps on the bottom row; the row test
        // masks that case.
        if (req.down) begin
          if (ypos_q == 8'(BOARD_H - 1) || grid_q[RB'(cy + 1'b1)][cx])
            state_d = LOCK;
          else
            ypos_d = ypos_q + 8'd1;
        end else if (req.left) begin
          if (xpos_q != 8'd0 && !grid_q[cy][CB'(cx - 1'b1)])
            xpos_d = xpos_q - 8'd1;
        end else if (req.right) begin
          if (xpos_q != 8'(BOARD_W - 1) && !grid_q[cy][CB'(cx + 1'b1)])
            xpos_d = xpos_q + 8'd1;
        end
      end
      LOCK: begin
        grid_d[cy][cx] = 1'b1;
        row_d          = RB'(BOARD_H - 1);
        state_d        = SCAN;
      end
      SCAN: begin
        if (&grid_q[row_q])
          state_d = SHIFT;
        else if (row_q == '0)
          state_d = SPAWN;
        else
          row_d = row_q - 1'b1;
      end
      SHIFT: begin
        // Collapse everything above row_q down by one. The scan then
        // re-examines the same row, which now holds what was above it.
        for (int k = BOARD_H - 1; k >= 1; k--) begin
          if (k <= int'(row_q))
            grid_d[k] = grid_q[k-1];
        end
        grid_d[0] = '0;
        if (score_q != 16'hFFFF)
          score_d = score_q + 16'd1;
        state_d = SCAN;
      end
      GAMEOVER: ;
      default: state_d = SPAWN;
    endcase
  end

  assign board       = grid_q;
  assign block_xpos  = xpos_q;
  assign block_ypos  = ypos_q;
  assign block_type  = `BLOCK_SINGLE;
  assign block_valid = (state_q == FALL);
  assign busy        = (state_q != FALL);
  assign game_over   = (state_q == GAMEOVER);
  assign score       = score_q;

endmodule
